load_scoreboard: RTL and testbench

Tracks destination registers of loads that have been issued but have not yet written back. Stalls the decode stage when a source operand depends on one of those results. It sits beside the EX/MEM/WB forwarding path as its producer-side counterpart. ALU results are forwarded, but load data is not available until writeback from the variable-latency memory port, so this block holds dependent instructions in ID until the data arrives.

---
 rtl/load_scoreboard.sv | 137 +++++++++++++
 tb/tb_load_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_scoreboard.sv
// load_scoreboard: per-register counters of loads issued but not yet written
// back. Decode stalls while a source operand depends on an in-flight load, or
// while the issuing load would overflow its destination's counter.
// Optional build macro LOAD_SCOREBOARD_STATS_EN adds the stall_cycles and
// full_cycles statistics outputs.
module load_scoreboard #(
    parameter int NUM_REGISTERS      = 32,
    parameter int NUM_REGISTERS_LOG2 = 5,
    parameter int CNT_BITS           = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rs,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rt,
    input  logic                          id_uses_rt,
    input  logic                          issue_valid,
    input  logic                          issue_is_load,
    input  logic [NUM_REGISTERS_LOG2-1:0] issue_rd,
    input  logic                          ld_done,
    input  logic [NUM_REGISTERS_LOG2-1:0] ld_rd,
    output logic                          stall,
    output logic [NUM_REGISTERS-1:0]      pending,
    output logic [3:0]                    outstanding
`ifdef LOAD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [31:0]                   full_cycles
`endif
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [CNT_BITS-1:0]      r_cnt      [NUM_REGISTERS];
    logic [CNT_BITS-1:0]      w_eff      [NUM_REGISTERS];
    logic [CNT_BITS-1:0]      w_cnt_next [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] w_done_hit;
    logic [NUM_REGISTERS-1:0] w_inc_hit;
    logic [NUM_REGISTERS-1:0] r_pending;
    logic [NUM_REGISTERS-1:0] w_pending_next;
    logic [3:0]               r_outstanding;
    logic [3:0]               w_outstanding_next;
    logic                     w_haz;
    logic                     w_full;
    logic                     w_stall;
    logic                     w_accept_load;
    logic                     w_done_counted;

    // Per-register effective count (completion this cycle already applied,
    // mirroring the register file's write-before-read) and next count.
    generate
        for (genvar gi = 0; gi < NUM_REGISTERS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // Register 0 is hardwired zero and never tracked.
                assign w_done_hit[gi] = 1'b0;
                assign w_inc_hit[gi]  = 1'b0;
                assign w_eff[gi]      = '0;
                assign w_cnt_next[gi] = '0;
            end else begin : g_track
                assign w_done_hit[gi] = ld_done && (ld_rd == NUM_REGISTERS_LOG2'(gi))
                                        && (r_cnt[gi] != '0);
                assign w_inc_hit[gi]  = w_accept_load
                                        && (issue_rd == NUM_REGISTERS_LOG2'(gi));
                assign w_eff[gi]      = w_done_hit[gi] ? (r_cnt[gi] - CNT_ONE) : r_cnt[gi];
                assign w_cnt_next[gi] = w_inc_hit[gi] ? (w_eff[gi] + CNT_ONE) : w_eff[gi];
            end
            assign w_pending_next[gi] = (w_cnt_next[gi] != '0);
        end
    endgenerate

    // Hazard / full detection and issue acceptance.
    assign w_haz = ((id_rs != '0) && (w_eff[id_rs] != '0))
                || (id_uses_rt && (id_rt != '0) && (w_eff[id_rt] != '0));
    assign w_full = issue_is_load && (issue_rd != '0) && (w_eff[issue_rd] == CNT_MAX);
    assign w_stall = issue_valid && (w_haz || w_full);
    assign w_accept_load = issue_valid && !w_stall && issue_is_load && (issue_rd != '0);
    assign w_done_counted = |w_done_hit;

    // Saturating in-flight total; simultaneous accept and completion cancel.
    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_accept_load && !w_done_counted) begin
            if (r_outstanding != 4'hF) begin
                w_outstanding_next = r_outstanding + 4'd1;
            end
        end else if (!w_accept_load && w_done_counted) begin
            if (r_outstanding != 4'h0) begin
                w_outstanding_next = r_outstanding - 4'd1;
            end
        end
    end

    // State registers: counters, pending mask and outstanding total.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                r_cnt[i] <= '0;
            end
            r_pending     <= '0;
            r_outstanding <= 4'h0;
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_pending     <= w_pending_next;
            r_outstanding <= w_outstanding_next;
        end
    end

    assign stall       = w_stall;
    assign pending     = r_pending;
    assign outstanding = r_outstanding;

`ifdef LOAD_SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_full_cycles;

    // Stall statistics; full_cycles counts stalls caused by counter overflow alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_full_cycles  <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_stall && w_full && !w_haz) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign full_cycles  = r_full_cycles;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
// Testbench for load_scoreboard: directed scenarios followed by random
// traffic, checked against an integer reference model via an expectation queue.
module tb_load_scoreboard;

    localparam int NR      = 32;
    localparam int CNT_MAX = 3;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        issue_valid;
    logic        issue_is_load;
    logic [4:0]  issue_rd;
    logic        ld_done;
    logic [4:0]  ld_rd;
    logic        stall;
    logic [31:0] pending;
    logic [3:0]  outstanding;
`ifdef LOAD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] full_cycles;
`endif

    load_scoreboard #(
        .NUM_REGISTERS      (NR),
        .NUM_REGISTERS_LOG2 (5),
        .CNT_BITS           (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .issue_valid   (issue_valid),
        .issue_is_load (issue_is_load),
        .issue_rd      (issue_rd),
        .ld_done       (ld_done),
        .ld_rd         (ld_rd),
        .stall         (stall),
        .pending       (pending),
        .outstanding   (outstanding)
`ifdef LOAD_SCOREBOARD_STATS_EN
        ,
        .stall_cycles  (stall_cycles),
        .full_cycles   (full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        stall;
        int          dir_stall;   // -1: no directed expectation
        logic [31:0] pending;
        logic [3:0]  outstanding;
        logic [31:0] stall_cycles;
        logic [31:0] full_cycles;
    } txn_t;

    txn_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int txn_id  = 0;

    // Reference model state: plain integers per register.
    int          cnt_m [NR];
    int          out_m = 0;
    logic [31:0] sc_m  = 0;
    logic [31:0] fc_m  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model and queue the expected result.
    task automatic cycle(input bit rst, input bit iv, input bit il, input int ird,
                         input int rs, input int rt, input bit urt,
                         input bit ld, input int ldrd, input int dir_stall);
        int   eff [NR];
        bit   haz, full, st, inc, dec;
        txn_t t;
        @(negedge clk);
        reset         = rst;
        issue_valid   = iv;
        issue_is_load = il;
        issue_rd      = 5'(ird);
        id_rs         = 5'(rs);
        id_rt         = 5'(rt);
        id_uses_rt    = urt;
        ld_done       = ld;
        ld_rd         = 5'(ldrd);

        for (int r = 0; r < NR; r++) begin
            eff[r] = cnt_m[r];
            if (ld && ldrd == r && r != 0 && cnt_m[r] > 0) eff[r] = eff[r] - 1;
        end
        haz  = (rs != 0 && eff[rs] > 0) || (urt && rt != 0 && eff[rt] > 0);
        full = il && ird != 0 && eff[ird] == CNT_MAX;
        st   = iv && (haz || full);

        if (rst) begin
            for (int r = 0; r < NR; r++) cnt_m[r] = 0;
            out_m = 0;
            sc_m  = 0;
            fc_m  = 0;
        end else begin
            dec = ld && ldrd != 0 && cnt_m[ldrd] > 0;
            inc = iv && !st && il && ird != 0;
            if (dec) cnt_m[ldrd] = cnt_m[ldrd] - 1;
            if (inc) cnt_m[ird]  = cnt_m[ird] + 1;
            out_m = out_m + int'(inc) - int'(dec);
            if (out_m > 15) out_m = 15;
            if (out_m < 0)  out_m = 0;
            if (st) sc_m = sc_m + 1;
            if (st && full && !haz) fc_m = fc_m + 1;
        end

        t.id          = txn_id;
        t.stall       = st;
        t.dir_stall   = dir_stall;
        t.pending     = '0;
        for (int r = 0; r < NR; r++) t.pending[r] = (cnt_m[r] > 0);
        t.outstanding = 4'(out_m);
        t.stall_cycles = sc_m;
        t.full_cycles  = fc_m;
        exp_q.push_back(t);
        txn_id++;
    endtask

    // Monitor: sample stall mid-cycle, registered outputs just after the edge.
    initial begin
        logic s_stall;
        txn_t t;
        forever begin
            @(negedge clk);
            #3;
            s_stall = stall;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                chk("stall", 32'(s_stall), 32'(t.stall));
                if (t.dir_stall >= 0) chk("directed_stall", 32'(s_stall), 32'(t.dir_stall));
                chk("pending", pending, t.pending);
                chk("outstanding", 32'(outstanding), 32'(t.outstanding));
`ifdef LOAD_SCOREBOARD_STATS_EN
                chk("stall_cycles", stall_cycles, t.stall_cycles);
                chk("full_cycles", full_cycles, t.full_cycles);
`endif
                $display("txn %0d stall=%0b pending=%08h outstanding=%0d",
                         t.id, s_stall, pending, outstanding);
            end
        end
    end

    initial begin
        for (int r = 0; r < NR; r++) cnt_m[r] = 0;
        reset = 1'b1; issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = '0;
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ld_done = 1'b0; ld_rd = '0;

        // Reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use hazard on r5, released by same-cycle ld_done
        cycle(0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 5, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 5, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 5, 0, 0, 1, 5, 0);

        // Register 0 never tracked
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

        // Counter saturation on r7
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 7, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 1, 7, 0, 0, 0, 1, 7, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

        // Simultaneous issue and done on r9
        cycle(0, 1, 1, 9, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 9, 0, 0, 0, 1, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

        // rt gating and stale completion
        cycle(0, 1, 1, 4, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 4, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 4, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);

        // Reset mid-operation, then a stale pre-reset completion
        cycle(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 2, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        // Random traffic over a small register window to provoke hazards
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 6),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 3),
                  int'($urandom_range(0, 8)),
                  -1);
        end

        // Drain
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
